// File: rtl/router_ctrl_fsm.sv
// router_ctrl_fsm
// Packet-level controller for the 1x3 router. Watches the incoming byte
// stream, waits for the addressed FIFO to drain when needed, and sequences
// header, payload and parity loading. A destination soft reset sends it back
// to address decode.
//
// Ports:
//   clock                      rising-edge clock
//   resetn                     synchronous, active-low reset
//   pkt_valid                  input byte valid (falling edge marks parity byte)
//   data_in[1:0]               low bits of current byte (address while decoding)
//   fifo_full                  full flag of the addressed FIFO
//   fifo_empty_0/1/2           destination FIFO empty flags
//   soft_reset_0/1/2           per-port timeout resets
//   parity_done                register block has stored the parity byte
//   low_pkt_valid              pkt_valid dropped while stalled
//   detect_add                 in DECODE_ADDRESS
//   lfd_state                  in LOAD_FIRST_DATA
//   ld_state                   in LOAD_DATA
//   full_state                 in FIFO_FULL_STATE
//   laf_state                  in LOAD_AFTER_FULL
//   write_enb_reg              FIFO write requested this cycle
//   rst_int_reg                in CHECK_PARITY_ERROR
//   busy                       upstream must hold the current byte
module router_ctrl_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    WAIT_TILL_EMPTY    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] addr_q;
  logic       hdr_empty;
  logic       emp;
  logic       sr;

  // Flag selection. While decoding, the header byte itself picks the FIFO
  // whose empty flag decides between loading and waiting. Everywhere else the
  // latched address picks the empty flag and the soft reset. Address 3 is not
  // a real port, so it selects nothing.
  always_comb begin
    hdr_empty = 1'b0;
    emp       = 1'b0;
    sr        = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
    case (addr_q)
      2'd0: begin
        emp = fifo_empty_0;
        sr  = soft_reset_0;
      end
      2'd1: begin
        emp = fifo_empty_1;
        sr  = soft_reset_1;
      end
      2'd2: begin
        emp = fifo_empty_2;
        sr  = soft_reset_2;
      end
      default: begin
        emp = 1'b0;
        sr  = 1'b0;
      end
    endcase
  end

  // Next-state logic. A soft reset of the addressed port aborts whatever the
  // packet was doing and returns to decode; in decode it is meaningless.
  // While loading, a full FIFO takes priority over pkt_valid falling so the
  // byte in flight is not lost.
  always_comb begin
    next_state = state;
    if (sr && (state != DECODE_ADDRESS)) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid && (data_in != 2'd3))
            next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)
            next_state = FIFO_FULL_STATE;
          else if (!pkt_valid)
            next_state = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full)
            next_state = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)
            next_state = DECODE_ADDRESS;
          else if (low_pkt_valid)
            next_state = LOAD_PARITY;
          else
            next_state = LOAD_DATA;
        end
        WAIT_TILL_EMPTY: begin
          if (emp)
            next_state = LOAD_FIRST_DATA;
        end
        LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // State, address and output registers. The outputs are registered from the
  // next state so that they change on the same edge as the state register and
  // always equal a pure decode of it. The address is captured from any valid
  // byte seen in decode, and a soft reset deliberately leaves it alone.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= DECODE_ADDRESS;
      addr_q        <= 2'd0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      full_state    <= 1'b0;
      laf_state     <= 1'b0;
      write_enb_reg <= 1'b0;
      rst_int_reg   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == DECODE_ADDRESS) && pkt_valid)
        addr_q <= data_in;
      detect_add    <= (next_state == DECODE_ADDRESS);
      lfd_state     <= (next_state == LOAD_FIRST_DATA);
      ld_state      <= (next_state == LOAD_DATA);
      full_state    <= (next_state == FIFO_FULL_STATE);
      laf_state     <= (next_state == LOAD_AFTER_FULL);
      rst_int_reg   <= (next_state == CHECK_PARITY_ERROR);
      write_enb_reg <= (next_state == LOAD_DATA) ||
                       (next_state == LOAD_PARITY) ||
                       (next_state == LOAD_AFTER_FULL);
      busy          <= (next_state != DECODE_ADDRESS) &&
                       (next_state != LOAD_DATA);
    end
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// tb_router_ctrl_fsm
// Self-checking bench for router_ctrl_fsm. Each scenario task drives a table
// of per-cycle inputs, pushes the expected output vector for the following
// cycle into a scoreboard queue, and pops/compares after the clock edge.
// Output vector layout: {detect_add, lfd_state, ld_state, full_state,
//                        laf_state, write_enb_reg, rst_int_reg, busy}
module tb_router_ctrl_fsm;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       full_state;
  logic       laf_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  localparam logic [7:0] E_DA  = 8'b1000_0000;
  localparam logic [7:0] E_LFD = 8'b0100_0001;
  localparam logic [7:0] E_LD  = 8'b0010_0100;
  localparam logic [7:0] E_FFS = 8'b0001_0001;
  localparam logic [7:0] E_LAF = 8'b0000_1101;
  localparam logic [7:0] E_WTE = 8'b0000_0001;
  localparam logic [7:0] E_LP  = 8'b0000_0101;
  localparam logic [7:0] E_CPE = 8'b0000_0011;

  router_ctrl_fsm dut (
    .clock(clock),
    .resetn(resetn),
    .pkt_valid(pkt_valid),
    .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0),
    .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0),
    .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2),
    .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add),
    .lfd_state(lfd_state),
    .ld_state(ld_state),
    .full_state(full_state),
    .laf_state(laf_state),
    .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg),
    .busy(busy)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard bound on the whole run so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus word: {pkt_valid, data_in[1:0], fifo_full, empty{2,1,0},
  //                 soft_reset{2,1,0}, parity_done, low_pkt_valid}
  function automatic logic [11:0] S(input logic pv, input logic [1:0] d,
                                    input logic ff, input logic [2:0] e,
                                    input logic [2:0] sr, input logic pd,
                                    input logic lpv);
    return {pv, d, ff, e, sr, pd, lpv};
  endfunction

  function automatic logic [7:0] outs();
    return {detect_add, lfd_state, ld_state, full_state, laf_state,
            write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic applyStimulus(input logic [11:0] s);
    pkt_valid     = s[11];
    data_in       = s[10:9];
    fifo_full     = s[8];
    fifo_empty_2  = s[7];
    fifo_empty_1  = s[6];
    fifo_empty_0  = s[5];
    soft_reset_2  = s[4];
    soft_reset_1  = s[3];
    soft_reset_0  = s[2];
    parity_done   = s[1];
    low_pkt_valid = s[0];
  endtask

  // Advance one rising edge and settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got, want;
    resetn = 1'b0;
    applyStimulus(S(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(E_DA);
      tick();
      got = outs(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL reset step %0d: got %b expected %b", i, got, want);
      end
    end
    resetn = 1'b1;
    applyStimulus(S(1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0));
    exp_q.push_back(E_DA);
    tick();
    got = outs(); want = exp_q.pop_front(); tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got %b expected %b", got, want);
    end
  endtask

  task automatic test_normal_packet();
    logic [11:0] stim [8];
    logic [7:0]  expv [8];
    logic [7:0]  got, want;
    int wr_count = 0;
    int ri_count = 0;
    stim = '{S(1,1,0,3'b010,0,0,0), S(1,1,0,3'b010,0,0,0), S(1,1,0,3'b010,0,0,0),
             S(1,1,0,3'b010,0,0,0), S(1,1,0,3'b010,0,0,0), S(0,1,0,3'b010,0,0,0),
             S(0,1,0,3'b010,0,0,0), S(0,1,0,3'b010,0,0,0)};
    expv = '{E_LFD, E_LD, E_LD, E_LD, E_LD, E_LP, E_CPE, E_DA};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(stim[i]);
      exp_q.push_back(expv[i]);
      tick();
      got = outs(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL normal_pkt step %0d: got %b expected %b", i, got, want);
      end
      if (write_enb_reg) wr_count++;
      if (rst_int_reg)   ri_count++;
    end
    tests_run++;
    if (wr_count !== 5) begin
      tests_failed++;
      $display("[TB] FAIL normal_pkt_write_count: got %0d expected 5", wr_count);
    end
    tests_run++;
    if (ri_count !== 1) begin
      tests_failed++;
      $display("[TB] FAIL normal_pkt_rst_int_count: got %0d expected 1", ri_count);
    end
  endtask

  task automatic test_busy_destination();
    logic [11:0] stim [11];
    logic [7:0]  expv [11];
    logic [7:0]  got, want;
    stim = '{S(1,2,0,3'b001,0,0,0), S(1,2,0,3'b001,0,0,0), S(1,2,0,3'b001,0,0,0),
             S(1,2,0,3'b001,0,0,0), S(1,2,0,3'b001,0,0,0), S(1,2,0,3'b001,0,0,0),
             S(1,2,0,3'b101,0,0,0), S(1,2,0,3'b101,0,0,0), S(0,2,0,3'b101,0,0,0),
             S(0,2,0,3'b101,0,0,0), S(0,2,0,3'b101,0,0,0)};
    expv = '{E_WTE, E_WTE, E_WTE, E_WTE, E_WTE, E_WTE,
             E_LFD, E_LD, E_LP, E_CPE, E_DA};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(stim[i]);
      exp_q.push_back(expv[i]);
      tick();
      got = outs(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL busy_dest step %0d: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_stall();
    logic [11:0] stim [10];
    logic [7:0]  expv [10];
    logic [7:0]  got, want;
    stim = '{S(1,0,0,3'b001,0,0,0), S(1,0,0,3'b001,0,0,0), S(1,0,0,3'b001,0,0,0),
             S(0,0,1,3'b001,0,0,0), S(0,0,1,3'b001,0,0,0), S(0,0,1,3'b001,0,0,0),
             S(0,0,0,3'b001,0,0,1), S(0,0,0,3'b001,0,0,1), S(0,0,0,3'b001,0,0,0),
             S(0,0,0,3'b001,0,0,0)};
    expv = '{E_LFD, E_LD, E_LD, E_FFS, E_FFS, E_FFS, E_LAF, E_LP, E_CPE, E_DA};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(stim[i]);
      exp_q.push_back(expv[i]);
      tick();
      got = outs(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL stall step %0d: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_soft_reset();
    logic [11:0] stim [9];
    logic [7:0]  expv [9];
    logic [7:0]  got, want;
    stim = '{S(1,0,0,3'b000,3'b000,0,0), S(1,0,0,3'b000,3'b010,0,0),
             S(1,0,0,3'b000,3'b000,0,0), S(1,0,0,3'b000,3'b001,0,0),
             S(0,0,0,3'b000,3'b000,0,0), S(1,2,0,3'b100,3'b000,0,0),
             S(1,2,0,3'b100,3'b001,0,0), S(1,2,0,3'b100,3'b100,0,0),
             S(0,2,0,3'b100,3'b000,0,0)};
    expv = '{E_WTE, E_WTE, E_WTE, E_DA, E_DA, E_LFD, E_LD, E_DA, E_DA};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(stim[i]);
      exp_q.push_back(expv[i]);
      tick();
      got = outs(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL soft_reset step %0d: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_invalid_address();
    logic [11:0] stim [4];
    logic [7:0]  expv [4];
    logic [7:0]  got, want;
    stim = '{S(1,3,0,3'b111,3'b000,0,0), S(1,3,0,3'b111,3'b000,0,0),
             S(1,3,0,3'b111,3'b000,0,0), S(1,3,0,3'b111,3'b111,0,0)};
    expv = '{E_DA, E_DA, E_DA, E_DA};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(stim[i]);
      exp_q.push_back(expv[i]);
      tick();
      got = outs(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL invalid_addr step %0d: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] stim [20];
    logic [7:0]  expv [20];
    logic [7:0]  got, want;
    stim = '{S(1,1,0,3'b111,0,0,0), S(1,1,0,3'b111,0,0,0), S(0,1,0,3'b111,0,0,0),
             S(0,1,0,3'b111,0,0,0), S(1,0,0,3'b111,0,0,0), S(1,0,0,3'b111,0,0,0),
             S(1,0,0,3'b111,0,0,0), S(0,0,0,3'b111,0,0,0), S(0,0,1,3'b111,0,0,0),
             S(0,0,1,3'b111,0,0,0), S(0,0,0,3'b111,0,1,0), S(0,0,0,3'b111,0,1,1),
             S(1,2,0,3'b111,0,0,0), S(1,2,0,3'b111,0,0,0), S(1,2,1,3'b111,0,0,0),
             S(1,2,0,3'b111,0,0,0), S(1,2,0,3'b111,0,0,0), S(0,2,0,3'b111,0,0,0),
             S(0,2,0,3'b111,0,0,0), S(0,2,0,3'b111,0,0,0)};
    expv = '{E_LFD, E_LD, E_LP, E_CPE, E_DA, E_LFD, E_LD, E_LP, E_CPE, E_FFS,
             E_LAF, E_DA, E_LFD, E_LD, E_FFS, E_LAF, E_LD, E_LP, E_CPE, E_DA};
    for (int i = 0; i < 20; i++) begin
      applyStimulus(stim[i]);
      exp_q.push_back(expv[i]);
      tick();
      got = outs(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back step %0d: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] got, want;
    logic [7:0] expv [2];
    expv = '{E_LFD, E_LD};
    for (int i = 0; i < 2; i++) begin
      applyStimulus(S(1, 1, 0, 3'b111, 3'b000, 0, 0));
      exp_q.push_back(expv[i]);
      tick();
      got = outs(); want = exp_q.pop_front(); tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid step %0d: got %b expected %b", i, got, want);
      end
    end
    resetn = 1'b0;
    applyStimulus(S(1, 1, 1, 3'b111, 3'b000, 0, 0));
    exp_q.push_back(E_DA);
    tick();
    got = outs(); want = exp_q.pop_front(); tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_abort: got %b expected %b", got, want);
    end
    resetn = 1'b1;
    applyStimulus(S(0, 0, 0, 3'b000, 3'b000, 0, 0));
    exp_q.push_back(E_DA);
    tick();
    got = outs(); want = exp_q.pop_front(); tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_idle: got %b expected %b", got, want);
    end
  endtask

  // Scenario sequence; each task leaves the controller back in decode.
  initial begin
    resetn = 1'b0;
    applyStimulus(S(0, 0, 0, 3'b000, 3'b000, 0, 0));
    @(negedge clock);
    test_reset();
    test_normal_packet();
    test_busy_destination();
    test_stall();
    test_soft_reset();
    test_invalid_address();
    test_back_to_back();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
# router_ctrl_fsm

Packet-level controller for the 1x3 router, directly upstream of the write-enable/soft-reset synchroniser. It watches the incoming byte stream (`pkt_valid`, 2-bit destination address), waits for the destination FIFO to drain if needed, and sequences header, payload and parity loading. It drives `detect_add` and `write_enb_reg` into the synchroniser and the state strobes into the register block. It also returns to address decode when a destination soft reset fires.

## Interface
- Parameters: none. Address width is fixed at 2; three destination ports.
- `clock` in 1: rising-edge clock.
- `resetn` in 1: synchronous, active-low reset.
- `pkt_valid` in 1: input byte valid; its falling edge marks the parity byte.
- `data_in` in 2: `data_in[1:0]` of the current byte; this is the destination address when in decode.
- `fifo_full` in 1: full flag of the currently addressed FIFO, from the synchroniser.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: destination FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-port timeout resets from the synchroniser.
- `parity_done` in 1: register block has stored the parity byte.
- `low_pkt_valid` in 1: register block saw `pkt_valid` drop while stalled.
- `detect_add` out 1: in DECODE_ADDRESS; the synchroniser latches the address on it.
- `lfd_state` out 1: in LOAD_FIRST_DATA.
- `ld_state` out 1: in LOAD_DATA.
- `full_state` out 1: in FIFO_FULL_STATE.
- `laf_state` out 1: in LOAD_AFTER_FULL.
- `write_enb_reg` out 1: a FIFO write is requested this cycle.
- `rst_int_reg` out 1: in CHECK_PARITY_ERROR; clears the register block's internal parity state.
- `busy` out 1: upstream must hold the current byte.

## Operation
- Eight states, registered 3-bit encoding:
  - DECODE_ADDRESS (DA)
  - LOAD_FIRST_DATA (LFD)
  - LOAD_DATA (LD)
  - FIFO_FULL_STATE (FFS)
  - LOAD_AFTER_FULL (LAF)
  - WAIT_TILL_EMPTY (WTE)
  - LOAD_PARITY (LP)
  - CHECK_PARITY_ERROR (CPE)
- `addr_q` (2 bits) is loaded from `data_in` when state is DA and `pkt_valid`=1; it holds otherwise. Reset value is 0.
- Selected empty flag `emp` = `fifo_empty_[addr_q]`. In DA, the flag indexed by `data_in` is used instead. Selected soft reset `sr` = `soft_reset_[addr_q]`. Address 3 selects nothing: `emp`=0, `sr`=0.
- Transitions:
  - DA: if `pkt_valid` and `data_in`<3 and `fifo_empty_[data_in]`, go to LFD. If `pkt_valid` and `data_in`<3 and not empty, go to WTE. Otherwise (including `data_in`=3) stay in DA; the byte is dropped.
  - LFD: go to LD unconditionally.
  - LD: if `fifo_full`, go to FFS. Else if `!pkt_valid`, go to LP. Else stay in LD.
  - FFS: if `!fifo_full`, go to LAF; else stay in FFS.
  - LAF: if `parity_done`, go to DA. Else if `low_pkt_valid`, go to LP. Else go to LD.
  - WTE: if `emp`, go to LFD; else stay in WTE.
  - LP: go to CPE unconditionally.
  - CPE: if `fifo_full`, go to FFS; else go to DA.
- Priority for the next state: `!resetn` (go to DA), then `sr`=1 in any state other than DA (go to DA), then the table above.
- Outputs are Moore and decoded combinationally from the state register:
  - `detect_add` = DA
  - `lfd_state` = LFD
  - `ld_state` = LD
  - `full_state` = FFS
  - `laf_state` = LAF
  - `rst_int_reg` = CPE
  - `write_enb_reg` = LD | LP | LAF
  - `busy` = LFD | FFS | LAF | WTE | LP | CPE (0 in DA and LD)

## Timing
- Reset values (the cycle after a clock edge with `resetn`=0): state=DA, `addr_q`=0.
  - `detect_add`=1; every other output 0, including `busy`.
- All state changes occur on the rising edge of `clock`; outputs follow the state with zero additional latency.
- Header latency: `pkt_valid`=1 in DA with an empty destination gives LFD on the next cycle and LD the cycle after. The first `write_enb_reg`=1 occurs 2 cycles after the header byte.
- Parity: `pkt_valid` falling while in LD gives exactly one LP cycle, then exactly one CPE cycle (`rst_int_reg` pulse of width 1).
- `fifo_full` sampled in LD and `pkt_valid` falling in the same cycle: full wins, so the next state is FFS.
- `sr` asserted on the same cycle as any transition condition: the next state is DA. `addr_q` is not cleared.
- `resetn` low mid-packet: DA on the next edge regardless of state.
- Back-to-back packets: CPE goes to DA, and DA may accept a new header on its first cycle.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles, release -> `detect_add`=1, `busy`=0, `write_enb_reg`=0.
- Normal packet to port 1: `pkt_valid`=1, `data_in`=01, `fifo_empty_1`=1, 4 payload bytes, then `pkt_valid`=0 -> state sequence DA, LFD, LD×4, LP, CPE, DA; `write_enb_reg` high for exactly 5 cycles; `rst_int_reg` high 1 cycle.
- Busy destination: header `data_in`=10 with `fifo_empty_2`=0 for 6 cycles, then 1 -> WTE for 6 cycles with `busy`=1, then LFD.
- Stall: assert `fifo_full` during LD for 3 cycles, then deassert with `low_pkt_valid`=1 -> FFS×3, LAF, LP, CPE, DA; `write_enb_reg`=0 during FFS.
- Soft reset: in WTE with `addr_q`=0, pulse `soft_reset_0` for 1 cycle -> DA on the next cycle, `busy`=0. A pulse on `soft_reset_1` in the same state has no effect.
- Invalid address: `pkt_valid`=1, `data_in`=11 -> remains in DA; `busy`=0; no `write_enb_reg`.
